crossdomain_signal_bank: RTL
============================

// Module: crossdomain_signal_bank
// PURPOSE
//  Multi-channel level synchroniser into the clk_b domain, with configurable synchroniser depth and per-channel reset value.
//  Generates registered one-cycle rise/fall strobes per channel.
//  Has an optional per-channel stability (glitch) filter.
//  Sits at every clock-domain boundary carrying slow control levels, e.g. buttons, MIDI status and codec ready flags.
// PARAMETERS
//  NUM_CH       4     number of independent 1-bit channels (>=1)
//  SYNC_STAGES  2     flip-flops per synchroniser chain (>=2)
//  INIT_VAL     0     NUM_CH-bit reset value of chains and outputs (bit i -> channel i)
//  FILT_CYCLES  4     consecutive stable clk_b cycles required before output changes (>=1; used only with filter)
// PORTS
//  clk_b         in   1       destination-domain clock
//  reset         in   1       asynchronous, active-high reset
//  sig_domain_a  in   NUM_CH  source-domain levels, asynchronous to clk_b
//  sig_domain_b  out  NUM_CH  synchronised (and optionally filtered) levels
//  rise_b        out  NUM_CH  1-cycle strobe: channel output went 0->1
//  fall_b        out  NUM_CH  1-cycle strobe: channel output went 1->0
//  any_edge_b    out  1       OR of all rise_b|fall_b bits, same cycle
// BEHAVIOUR
//  - Reset (async assert, sync release via clk_b): all chain flops, sig_domain_b and prev copies take INIT_VAL.
//    rise_b, fall_b and any_edge_b are 0, and filter counters are 0. Asserting reset mid-operation discards any change in flight.
//  - Sync chain per channel: stage0 <= sig_domain_a[i]; stage k <= stage k-1. Only stage0 samples the async input.
//    sync_out = stage SYNC_STAGES-1.
//  - Unfiltered path: sig_domain_b = sync_out. An input change that meets setup before edge N is visible after edge N+SYNC_STAGES-1.
//    Latency is SYNC_STAGES clk_b edges.
//  - Strobes: prev_q <= sig_domain_b every cycle. rise_b = sig_domain_b & ~prev_q and fall_b = ~sig_domain_b & prev_q.
//    Both are driven from registers, so each strobe is high for exactly one cycle, coincident with the first cycle of the new level.
//    rise_b and fall_b are never both set on one channel. Channels are fully independent, and simultaneous edges on several channels each strobe.
//  - Pulses on sig_domain_a shorter than one clk_b period may be lost or stretched to one cycle. This is a documented limitation.
//    Such inputs must be level-held by the source.
//  - Wide words are NOT coherent across channels: a multi-bit value may transition across differing cycles.
// CONFIGURATION
//  Macro CROSSDOMAIN_SIGNAL_FILTER_EN:
//  - Defined: per-channel counter cnt, width $clog2(FILT_CYCLES+1), inserted after sync_out.
//    - Each clk_b cycle, if sync_out == sig_domain_b: cnt <= 0.
//    - Else if cnt == FILT_CYCLES-1: sig_domain_b <= sync_out and cnt <= 0.
//    - Else: cnt <= cnt+1.
//    - Effect: the output changes only after FILT_CYCLES consecutive differing samples. Any bounce back restarts the count.
//    - Latency is SYNC_STAGES+FILT_CYCLES edges.
//    - Strobes follow the filtered sig_domain_b.
//  - Undefined: no counters; sig_domain_b is the unfiltered path and FILT_CYCLES is ignored.
// TESTING (NUM_CH=4, SYNC_STAGES=2, INIT_VAL=4'b0101, FILT_CYCLES=4)
//  1. Reset held 3 cycles, then released:
//     -> sig_domain_b = 4'b0101; rise_b, fall_b and any_edge_b are 0.
//  2. No filter: sig_domain_a 4'b0101 -> 4'b0111, set 1ns after edge 0:
//     -> sig_domain_b = 4'b0111 after edge 2.
//     -> rise_b = 4'b0010 and any_edge_b = 1 for exactly that cycle, then both return to 0.
//  3. No filter: ch0 1->0 and ch3 0->1 in the same cycle:
//     -> rise_b = 4'b1000 and fall_b = 4'b0001 in the same single cycle.
//  4. Filter: ch1 set high for 3 cycles, then low:
//     -> sig_domain_b[1] stays 0 and no strobes.
//     Ch1 then held high:
//     -> sig_domain_b[1] = 1 exactly SYNC_STAGES+FILT_CYCLES = 6 edges after it was sampled, with a one-cycle rise_b[1].
//  5. Reset asserted asynchronously 1 cycle after a ch2 input change, while it is still in the chain:
//     -> outputs return immediately to 4'b0101 with no strobe.
//     -> after release, the held input propagates in SYNC_STAGES (no filter) edges and raises its strobe.
//  6. Random async toggling of all channels, 10k cycles, with a scoreboard model:
//     -> per channel, the number of rise/fall strobes matches the output transitions.
//     -> rise_b & fall_b is always 0.

Source files
------------

// File: rtl/crossdomain_signal_bank.sv
// ============================================================================
// crossdomain_signal_bank: multi-channel level synchroniser into clk_b with
// rise/fall strobes; optional glitch filter via CROSSDOMAIN_SIGNAL_FILTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crossdomain_signal_bank #(
   parameter int                NUM_CH      = 4,
   parameter int                SYNC_STAGES = 2,
   parameter logic [NUM_CH-1:0] INIT_VAL    = '0,
   parameter int                FILT_CYCLES = 4
) (
   input  logic              clk_b,
   input  logic              reset,
   input  logic [NUM_CH-1:0] sig_domain_a,
   output logic [NUM_CH-1:0] sig_domain_b,
   output logic [NUM_CH-1:0] rise_b,
   output logic [NUM_CH-1:0] fall_b,
   output logic              any_edge_b
);

   logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0] sync_out;
   logic [NUM_CH-1:0] prev_q;

   // Only stage 0 sees the asynchronous input; later stages resolve metastability.
   always_ff @(posedge clk_b or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= INIT_VAL;
         end
      end else begin
         sync_q[0] <= sig_domain_a;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CROSSDOMAIN_SIGNAL_FILTER_EN
   localparam int               CNT_W   = $clog2(FILT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

   logic [NUM_CH-1:0] filt_q;
   logic [NUM_CH-1:0] filt_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];

   // A channel only follows sync_out after FILT_CYCLES consecutive differing samples.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_out[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            filt_d[i] = sync_out[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_b or posedge reset) begin
      if (reset) begin
         filt_q <= INIT_VAL;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         filt_q <= filt_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sig_domain_b = filt_q;
`else
   assign sig_domain_b = sync_out;
`endif

   always_ff @(posedge clk_b or posedge reset) begin
      if (reset) begin
         prev_q <= INIT_VAL;
      end else begin
         prev_q <= sig_domain_b;
      end
   end

   // Both operands are flop outputs, so strobes are glitch-free and last one cycle.
   assign rise_b     = sig_domain_b & ~prev_q;
   assign fall_b     = ~sig_domain_b & prev_q;
   assign any_edge_b = |(rise_b | fall_b);

endmodule

`default_nettype wire
